// File: rtl/conv_pkg.sv
// Shared types for the convolution window feeder: scan FSM states and scan direction.
package conv_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, PRESENT, DONE} feed_state_e;
  typedef enum logic {DIR_LR, DIR_RL} scan_dir_e;

  function automatic scan_dir_e flip_dir(input scan_dir_e d);
    return (d == DIR_LR) ? DIR_RL : DIR_LR;
  endfunction

endpackage

// File: rtl/conv_col_addr_gen.sv
// Column address generator: tracks the address of the column being fetched and walks
// down it one image row at a time, counting issued reads.
module conv_col_addr_gen #(
  parameter int N     = 11,
  parameter int IMG_W = 64,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic          step_left,
  input  logic          step_right,
  input  logic          next_row,
  input  logic          fetch_begin,
  input  logic          issue,
  output logic [AW-1:0] rd_addr,
  output logic          issue_done
);

  localparam int CW = $clog2(N + 1);

  logic [AW-1:0] col_start_q, col_start_d;
  logic [AW-1:0] off_q, off_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    col_start_d = col_start_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    if (load) begin
      col_start_d = base;
    end else if (next_row) begin
      col_start_d = col_start_q + AW'(IMG_W);
    end else if (step_right) begin
      col_start_d = col_start_q + AW'(1);
    end else if (step_left) begin
      col_start_d = col_start_q - AW'(1);
    end
    // Offset runs down the column by one image row per accepted read.
    if (fetch_begin) begin
      off_d = '0;
      cnt_d = '0;
    end else if (issue) begin
      off_d = off_q + AW'(IMG_W);
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_start_q <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
    end else begin
      col_start_q <= col_start_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rd_addr    = col_start_q + off_q;
  assign issue_done = (cnt_q == CW'(N));

endmodule

// File: rtl/conv_window_feeder.sv
// Serpentine scan sequencer: fetches N-pixel image columns, shifts them into the
// kernel-window bank and hands each complete N x N window to the convolver.
module conv_window_feeder #(
  parameter int N     = 11,
  parameter int B     = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int AW    = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [AW-1:0]              img_base,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_req,
  output logic [AW-1:0]              rd_addr,
  input  logic                       rd_ready,
  input  logic                       rd_rvalid,
  input  logic [B-1:0]               rd_rdata,
  output logic [N*B-1:0]             col_data,
  output logic                       up_en,
  output logic                       down_en,
  output logic                       dir,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [$clog2(IMG_W)-1:0]   win_x,
  output logic [$clog2(IMG_H)-1:0]   win_y
);

  import conv_pkg::*;

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int FW = $clog2(N + 1);
  localparam logic [XW-1:0] X_END = XW'(IMG_W - N);
  localparam logic [YW-1:0] Y_END = YW'(IMG_H - N);

  if (N < 2 || N > IMG_W || N > IMG_H) begin : g_bad_geometry
    $error("conv_window_feeder: kernel size N must satisfy 1 < N <= IMG_W and N <= IMG_H");
  end
  if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << AW)) begin : g_bad_aw
    $error("conv_window_feeder: AW too narrow for IMG_W*IMG_H pixels");
  end

  feed_state_e           state_q, state_d;
  scan_dir_e             dir_q, dir_d;
  logic [XW-1:0]         win_x_q, win_x_d;
  logic [YW-1:0]         win_y_q, win_y_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic [FW-1:0]         rsp_cnt_q, rsp_cnt_d;
  logic [N-1:0][B-1:0]   col_data_q, col_data_d;

  logic ag_load, ag_step_left, ag_step_right, ag_next_row, ag_fetch_begin, ag_issue;
  logic ag_issue_done;
  logic row_end, last_row;

  conv_col_addr_gen #(
    .N     (N),
    .IMG_W (IMG_W),
    .AW    (AW)
  ) u_addr_gen (
    .clk         (clk),
    .rstn        (rstn),
    .load        (ag_load),
    .base        (img_base),
    .step_left   (ag_step_left),
    .step_right  (ag_step_right),
    .next_row    (ag_next_row),
    .fetch_begin (ag_fetch_begin),
    .issue       (ag_issue),
    .rd_addr     (rd_addr),
    .issue_done  (ag_issue_done)
  );

  assign row_end  = (dir_q == DIR_LR) ? (win_x_q == X_END) : (win_x_q == '0);
  assign last_row = (win_y_q == Y_END);

  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    win_x_d        = win_x_q;
    win_y_d        = win_y_q;
    fill_d         = fill_q;
    rsp_cnt_d      = rsp_cnt_q;
    col_data_d     = col_data_q;
    ag_load        = 1'b0;
    ag_step_left   = 1'b0;
    ag_step_right  = 1'b0;
    ag_next_row    = 1'b0;
    ag_fetch_begin = 1'b0;
    ag_issue       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ag_load        = 1'b1;
          ag_fetch_begin = 1'b1;
          dir_d          = DIR_LR;
          win_x_d        = '0;
          win_y_d        = '0;
          fill_d         = '0;
          rsp_cnt_d      = '0;
          state_d        = FETCH;
        end
      end
      FETCH: begin
        ag_issue = rd_req && rd_ready;
        if (rd_rvalid) begin
          for (int i = 0; i < N; i++) begin
            if (rsp_cnt_q == FW'(i)) col_data_d[i] = rd_rdata;
          end
          if (rsp_cnt_q == FW'(N - 1)) begin
            rsp_cnt_d = '0;
            state_d   = SHIFT;
          end else begin
            rsp_cnt_d = rsp_cnt_q + FW'(1);
          end
        end
      end
      SHIFT: begin
        // fill saturates at N, so a step shift always lands in PRESENT.
        if (fill_q < FW'(N - 1)) begin
          fill_d         = fill_q + FW'(1);
          ag_step_right  = (dir_q == DIR_LR);
          ag_step_left   = (dir_q == DIR_RL);
          ag_fetch_begin = 1'b1;
          state_d        = FETCH;
        end else begin
          fill_d  = FW'(N);
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (win_ready) begin
          if (row_end && last_row) begin
            state_d = DONE;
          end else if (row_end) begin
            // The refill of the next row starts at the column the previous row ended on.
            win_y_d        = win_y_q + YW'(1);
            dir_d          = flip_dir(dir_q);
            fill_d         = '0;
            ag_next_row    = 1'b1;
            ag_fetch_begin = 1'b1;
            state_d        = FETCH;
          end else begin
            win_x_d        = (dir_q == DIR_LR) ? win_x_q + XW'(1) : win_x_q - XW'(1);
            ag_step_right  = (dir_q == DIR_LR);
            ag_step_left   = (dir_q == DIR_RL);
            ag_fetch_begin = 1'b1;
            state_d        = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      dir_q      <= DIR_LR;
      win_x_q    <= '0;
      win_y_q    <= '0;
      fill_q     <= '0;
      rsp_cnt_q  <= '0;
      col_data_q <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      win_x_q    <= win_x_d;
      win_y_q    <= win_y_d;
      fill_q     <= fill_d;
      rsp_cnt_q  <= rsp_cnt_d;
      col_data_q <= col_data_d;
    end
  end

  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign rd_req    = (state_q == FETCH) && !ag_issue_done;
  assign up_en     = (state_q == SHIFT) && (dir_q == DIR_LR);
  assign down_en   = (state_q == SHIFT) && (dir_q == DIR_RL);
  assign dir       = (dir_q == DIR_RL);
  assign win_valid = (state_q == PRESENT);
  assign win_x     = win_x_q;
  assign win_y     = win_y_q;
  assign col_data  = col_data_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder on a 5x4 image with a 3x3 kernel; memory word = addr[7:0].
module tb_conv_window_feeder;

  localparam int N = 3, B = 8, IMG_W = 5, IMG_H = 4, AW = 16;
  localparam int XW = $clog2(IMG_W), YW = $clog2(IMG_H);
  localparam int NWIN = 6, NSHIFT = 10, NREAD = 30, TIMEOUT = 3000;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [AW-1:0] img_base = '0;
  logic busy, done, rd_req, up_en, down_en, dir, win_valid;
  logic [AW-1:0] rd_addr;
  logic rd_ready = 1'b0, rd_rvalid = 1'b0, win_ready = 1'b0;
  logic [B-1:0] rd_rdata = '0;
  logic [N*B-1:0] col_data;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;

  always #5 clk = ~clk;

  conv_window_feeder #(.N(N), .B(B), .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .img_base(img_base),
    .busy(busy), .done(done), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ready(rd_ready), .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .col_data(col_data), .up_en(up_en), .down_en(down_en), .dir(dir),
    .win_valid(win_valid), .win_ready(win_ready), .win_x(win_x), .win_y(win_y)
  );

  typedef struct { int x; int y; logic d; logic [B-1:0] px00; int reads; } win_vec_t;
  typedef struct { logic [B-1:0] data; int due; } rsp_t;

  win_vec_t tbl [NWIN];
  int n_checks = 0, n_errors = 0;
  bit rnd_mode = 1'b0, hold_en = 1'b0;
  int run_id = 0;

  // State below is written only by the responder/monitor process.
  int seen_id = 0, cyc = 0, last_due = 0, hold_left = 0, hold_viol = 0;
  int done_cnt = 0, done_busy_bad = 0, addr_hold_bad = 0;
  bit prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  rsp_t rq[$];
  int acc_x[$], acc_y[$], acc_reads[$];
  logic acc_dir[$];
  logic [N*N*B-1:0] acc_bank[$];
  logic [AW-1:0] rd_log[$];
  logic [N*B-1:0] sh_col[$];
  logic [1:0] sh_en[$];
  logic [B-1:0] bank [N][N];

  function automatic logic [B-1:0] pixel(input int row, input int col);
    return 8'(16'h0010 + row * IMG_W + col);
  endfunction

  function automatic logic [51:0] all_outs();
    return {busy, done, rd_req, rd_addr, col_data, up_en, down_en, dir, win_valid, win_x, win_y};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory responder, window consumer and bank model, all on the falling edge.
  always @(negedge clk) begin
    int lat, due;
    logic [N*N*B-1:0] snap;
    cyc++;
    if (seen_id != run_id) begin
      seen_id = run_id;
      acc_x.delete(); acc_y.delete(); acc_dir.delete(); acc_reads.delete(); acc_bank.delete();
      rd_log.delete(); sh_col.delete(); sh_en.delete();
      hold_left = 20; hold_viol = 0; done_cnt = 0; done_busy_bad = 0; addr_hold_bad = 0;
      for (int r = 0; r < N; r++) for (int i = 0; i < N; i++) bank[r][i] = '0;
    end
    rd_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      rd_rvalid = 1'b1;
      rd_rdata  = rq[0].data;
      rq.delete(0);
    end else begin
      rd_rvalid = 1'b0;
      rd_rdata  = '0;
    end
    win_ready = 1'b1;
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (hold_en && win_valid && win_x == 3'd1 && win_y == 2'd0 && hold_left > 0) begin
        win_ready = 1'b0;
        hold_left--;
        if (rd_req || up_en || down_en) hold_viol++;
      end
      if (up_en || down_en) begin
        for (int r = 0; r < N; r++) begin
          if (up_en) begin
            for (int i = N - 1; i > 0; i--) bank[r][i] = bank[r][i-1];
            bank[r][0] = col_data[r*B +: B];
          end else begin
            for (int i = 0; i < N - 1; i++) bank[r][i] = bank[r][i+1];
            bank[r][N-1] = col_data[r*B +: B];
          end
        end
        sh_col.push_back(col_data);
        sh_en.push_back({up_en, down_en});
      end
      if (win_valid && win_ready) begin
        for (int r = 0; r < N; r++) for (int i = 0; i < N; i++) snap[(r*N+i)*B +: B] = bank[r][i];
        acc_x.push_back(int'(win_x));
        acc_y.push_back(int'(win_y));
        acc_dir.push_back(dir);
        acc_bank.push_back(snap);
        acc_reads.push_back(rd_log.size());
      end
      if (done) begin
        done_cnt++;
        if (busy) done_busy_bad++;
      end
      if (prev_stall && rd_req && rd_addr != prev_addr) addr_hold_bad++;
      prev_stall = rd_req && !rd_ready;
      prev_addr  = rd_addr;
      if (rd_req && rd_ready) begin
        rd_log.push_back(rd_addr);
        lat = rnd_mode ? int'($urandom_range(1, 4)) : 1;
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        rq.push_back('{rd_addr[7:0], due});
      end
    end
  end

  task automatic run_scan(input string tag, input bit rnd, input bit hold, input bit busy_start);
    int t;
    int j;
    logic [N*N*B-1:0] exp_bank;
    rnd_mode = rnd;
    hold_en  = hold;
    run_id++;
    @(negedge clk);
    img_base = 16'h0010;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    img_base = 16'h0040;
    if (busy_start) begin
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == 0 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_finished"}, 128'(t < TIMEOUT), 128'd1);
    repeat (3) @(negedge clk);

    check({tag, "_n_windows"}, acc_x.size(), NWIN);
    for (int k = 0; k < NWIN && k < acc_x.size(); k++) begin
      check({tag, "_win_xyd"}, {acc_x[k], acc_y[k], acc_dir[k]}, {tbl[k].x, tbl[k].y, tbl[k].d});
      check({tag, "_win_px00"}, acc_bank[k][(N-1)*B +: B], tbl[k].px00);
      check({tag, "_win_reads"}, acc_reads[k], tbl[k].reads);
      for (int r = 0; r < N; r++)
        for (int i = 0; i < N; i++)
          exp_bank[(r*N+i)*B +: B] = pixel(tbl[k].y + r, tbl[k].x + N - 1 - i);
      check({tag, "_win_bank"}, acc_bank[k], exp_bank);
    end

    check({tag, "_n_reads"}, rd_log.size(), NREAD);
    j = 0;
    for (int y = 0; y <= IMG_H - N; y++) begin
      for (int k = 0; k < IMG_W; k++) begin
        int c;
        c = (y % 2 == 0) ? k : IMG_W - 1 - k;
        for (int r = 0; r < N; r++) begin
          if (j < rd_log.size()) check({tag, "_rd_addr"}, rd_log[j], 16'h0010 + (y + r) * IMG_W + c);
          j++;
        end
      end
    end

    check({tag, "_n_shifts"}, sh_en.size(), NSHIFT);
    for (int k = 0; k < NSHIFT && k < sh_en.size(); k++)
      check({tag, "_shift_en"}, sh_en[k], (k < 5) ? 2'b10 : 2'b01);
    if (sh_col.size() > 5) begin
      check({tag, "_step_col"}, sh_col[3], 24'h1D1813);
      check({tag, "_rl_fill_col"}, sh_col[5], 24'h231E19);
    end

    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_at_done"}, done_busy_bad, 0);
    check({tag, "_idle_after"}, {busy, rd_req, win_valid, up_en, down_en}, 0);
    check({tag, "_addr_hold"}, addr_hold_bad, 0);
    check({tag, "_rsp_drained"}, rq.size(), 0);
    if (hold) begin
      check({tag, "_hold_len"}, hold_left, 0);
      check({tag, "_hold_quiet"}, hold_viol, 0);
    end
    $display("run %s: %0d windows, %0d reads, %0d shifts", tag, acc_x.size(), rd_log.size(), sh_en.size());
  endtask

  task automatic run_abort();
    int t;
    rnd_mode = 1'b0;
    hold_en  = 1'b0;
    run_id++;
    @(negedge clk);
    img_base = 16'h0010;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (acc_x.size() < 4 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    check("abort_reach", 128'(t < TIMEOUT), 128'd1);
    repeat (2) @(negedge clk);
    check("abort_fetching", {busy, rd_req}, 2'b11);
    rstn = 1'b0;
    #1;
    check("abort_reset_outs", all_outs(), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_hold_outs", all_outs(), 0);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    $display("abort: reset applied after %0d windows", acc_x.size());
  endtask

  initial begin
    tbl[0] = '{0, 0, 1'b0, 8'h10, 9};
    tbl[1] = '{1, 0, 1'b0, 8'h11, 12};
    tbl[2] = '{2, 0, 1'b0, 8'h12, 15};
    tbl[3] = '{2, 1, 1'b1, 8'h17, 24};
    tbl[4] = '{1, 1, 1'b1, 8'h16, 27};
    tbl[5] = '{0, 1, 1'b1, 8'h15, 30};

    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    run_scan("basic", 1'b0, 1'b0, 1'b0);
    run_scan("hold", 1'b0, 1'b1, 1'b0);
    run_scan("random", 1'b1, 1'b0, 1'b0);
    run_abort();
    run_scan("rerun", 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
